res_seq_ctrl: RTL and testbench

RES_SEQ_CTRL -- requirements
Module: res_seq_ctrl

---
 rtl/res_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_res_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : res_seq_ctrl
// Description : Sequencer for a digit-serial residue datapath. Each operation
//               is one CLEAR cycle, then NUM_ITER iterations that each walk
//               NUM_DIGITS digit slices, then a one-cycle DONE pulse.
// Ports       : clk, asyn_reset              - clock, async active-high reset
//               start, abort, hold           - operation control inputs
//               busy, done                   - status outputs
//               iter_count, comp_cycle       - iteration and digit indices
//               read_addr, write_addr        - residue RAM addresses
//               carry_out_control, enable,
//               enable_shift, enable_V_reg   - datapath controls
// Revision    : 1.0 - initial release
// ============================================================================
module res_seq_ctrl #(
    parameter int RAM_ADDR_WIDTH = 7,
    parameter int NUM_DIGITS     = 8,
    parameter int NUM_ITER       = 16
) (
    input  logic                      clk,
    input  logic                      asyn_reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                iter_count,
    output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
    output logic [RAM_ADDR_WIDTH-1:0] read_addr,
    output logic [RAM_ADDR_WIDTH-1:0] write_addr,
    output logic [1:0]                carry_out_control,
    output logic                      enable,
    output logic                      enable_shift,
    output logic                      enable_V_reg
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_CLEAR = 2'd1;
    localparam logic [1:0] c_S_RUN   = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [RAM_ADDR_WIDTH-1:0] c_LAST_DIG  = RAM_ADDR_WIDTH'(NUM_DIGITS - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] c_DIG_ONE   = RAM_ADDR_WIDTH'(1);
    localparam logic [7:0]                c_LAST_ITER = 8'(NUM_ITER - 1);

    localparam logic [1:0] c_CC_CLEAR = 2'd0;
    localparam logic [1:0] c_CC_LOOP  = 2'd1;
    localparam logic [1:0] c_CC_VREG  = 2'd2;
    localparam logic [1:0] c_CC_NOP   = 2'd3;

    logic [1:0]                r_state;
    logic [RAM_ADDR_WIDTH-1:0] r_d;
    logic [7:0]                r_iter;
    logic                      w_last_dig;

    assign w_last_dig = (r_d == c_LAST_DIG);

    // State and counters. Abort outranks every other input; the counters are
    // left untouched by it because the next CLEAR reinitialises them anyway.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state <= c_S_IDLE;
            r_d     <= '0;
            r_iter  <= '0;
        end else if (abort) begin
            r_state <= c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state <= c_S_CLEAR;
                    end
                end
                c_S_CLEAR: begin
                    r_d     <= '0;
                    r_iter  <= '0;
                    r_state <= c_S_RUN;
                end
                c_S_RUN: begin
                    if (!hold) begin
                        if (!w_last_dig) begin
                            r_d <= r_d + c_DIG_ONE;
                        end else begin
                            r_d <= '0;
                            if (r_iter == c_LAST_ITER) begin
                                // iter_count keeps its final value through DONE/IDLE
                                r_state <= c_S_DONE;
                            end else begin
                                r_iter <= r_iter + 8'd1;
                            end
                        end
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only (plus hold, which must
    // stall the datapath in the very cycle it is raised). Because the state
    // registers clear asynchronously, every output reaches its reset value
    // as soon as asyn_reset rises.
    always_comb begin
        busy              = (r_state != c_S_IDLE);
        done              = (r_state == c_S_DONE);
        iter_count        = r_iter;
        comp_cycle        = r_d;
        write_addr        = r_d;
        read_addr         = w_last_dig ? '0 : (r_d + c_DIG_ONE);
        carry_out_control = c_CC_CLEAR;
        enable            = 1'b0;
        enable_shift      = 1'b0;
        enable_V_reg      = 1'b0;
        if (r_state == c_S_RUN) begin
            // Shift enable tracks the digit position even while held so the
            // inter-digit path stays consistent for the frozen digit.
            enable_shift = !w_last_dig;
            if (hold) begin
                carry_out_control = c_CC_NOP;
            end else begin
                enable = 1'b1;
                if (w_last_dig) begin
                    carry_out_control = c_CC_VREG;
                    enable_V_reg      = 1'b1;
                end else begin
                    carry_out_control = c_CC_LOOP;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_res_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_res_seq_ctrl
// Description : Self-checking bench for res_seq_ctrl (4 digits, 2 iterations).
//               Directed operation scenarios followed by random start, abort,
//               hold and reset traffic against a position-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_res_seq_ctrl;

    localparam int c_AW = 7;
    localparam int c_ND = 4;
    localparam int c_NI = 2;

    logic            clk = 1'b0;
    logic            asyn_reset;
    logic            start;
    logic            abort;
    logic            hold;
    logic            busy;
    logic            done;
    logic [7:0]      iter_count;
    logic [c_AW-1:0] comp_cycle;
    logic [c_AW-1:0] read_addr;
    logic [c_AW-1:0] write_addr;
    logic [1:0]      carry_out_control;
    logic            enable;
    logic            enable_shift;
    logic            enable_V_reg;

    res_seq_ctrl #(
        .RAM_ADDR_WIDTH(c_AW),
        .NUM_DIGITS    (c_ND),
        .NUM_ITER      (c_NI)
    ) u_dut (
        .clk              (clk),
        .asyn_reset       (asyn_reset),
        .start            (start),
        .abort            (abort),
        .hold             (hold),
        .busy             (busy),
        .done             (done),
        .iter_count       (iter_count),
        .comp_cycle       (comp_cycle),
        .read_addr        (read_addr),
        .write_addr       (write_addr),
        .carry_out_control(carry_out_control),
        .enable           (enable),
        .enable_shift     (enable_shift),
        .enable_V_reg     (enable_V_reg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: an operation is a phase plus a linear position through
    // the ND*NI digit steps; digit and iteration fall out by div/mod.
    localparam int c_PH_IDLE  = 0;
    localparam int c_PH_CLEAR = 1;
    localparam int c_PH_RUN   = 2;
    localparam int c_PH_DONE  = 3;
    int m_phase;
    int m_pos;
    bit m_cnt_ok;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = c_PH_IDLE;
        m_pos    = 0;
        m_cnt_ok = 1'b1;
    endtask

    task automatic model_edge();
        if (abort) begin
            m_phase  = c_PH_IDLE;
            m_cnt_ok = 1'b0;
        end else begin
            case (m_phase)
                c_PH_IDLE:  if (start) m_phase = c_PH_CLEAR;
                c_PH_CLEAR: begin m_phase = c_PH_RUN; m_pos = 0; m_cnt_ok = 1'b1; end
                c_PH_RUN: begin
                    if (!hold) begin
                        if (m_pos == c_ND * c_NI - 1) m_phase = c_PH_DONE;
                        else m_pos++;
                    end
                end
                default:    m_phase = c_PH_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        int  d;
        bit  run;
        int  cc;
        d   = m_pos % c_ND;
        run = (m_phase == c_PH_RUN);
        cc  = !run ? 0 : (hold ? 3 : ((d == c_ND - 1) ? 2 : 1));
        check("busy",  32'(busy), 32'(m_phase != c_PH_IDLE));
        check("done",  32'(done), 32'(m_phase == c_PH_DONE));
        check("coc",   32'(carry_out_control), 32'(cc));
        check("en",    32'(enable), 32'(run && !hold));
        check("en_sh", 32'(enable_shift), 32'(run && (d != c_ND - 1)));
        check("en_v",  32'(enable_V_reg), 32'(run && !hold && (d == c_ND - 1)));
        if (m_cnt_ok) check("iter", 32'(iter_count), 32'(m_pos / c_ND));
        if (run) begin
            check("comp",  32'(comp_cycle), 32'(d));
            check("waddr", 32'(write_addr), 32'(d));
            check("raddr", 32'(read_addr), 32'((d + 1) % c_ND));
        end
    endtask

    task automatic step(input bit s, input bit a, input bit h);
        start = s;
        abort = a;
        hold  = h;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset raised mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_reset_midcycle();
        #2;
        asyn_reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_coc",  32'(carry_out_control), 32'd0);
        check("rst_en",   32'({enable, enable_shift, enable_V_reg}), 32'd0);
        check("rst_comp", 32'(comp_cycle), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        model_reset();
        @(negedge clk);
        asyn_reset = 1'b0;
    endtask

    int done_at;
    int busy_n;
    int rise_at;
    bit prev_busy;
    int exp_seq [8] = '{1, 1, 1, 2, 1, 1, 1, 2};
    int coc_seq [8];

    initial begin
        asyn_reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_comp", 32'(comp_cycle), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;

        // Basic operation: cycle count, carry control sequence, busy span
        step(1, 0, 0);
        busy_n  = busy ? 1 : 0;
        done_at = -1;
        for (int k = 2; k <= 14; k++) begin
            step(0, 0, 0);
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = k;
            if (k <= 9) coc_seq[k-2] = int'(carry_out_control);
        end
        check("done_cycle", 32'(done_at), 32'd10);
        check("busy_cycles", 32'(busy_n), 32'd10);
        for (int i = 0; i < 8; i++) check("coc_seq", 32'(coc_seq[i]), 32'(exp_seq[i]));

        // Hold for three cycles at digit 2
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pre_hold_d", 32'(comp_cycle), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1);
            check("hold_comp", 32'(comp_cycle), 32'd2);
            check("hold_coc",  32'(carry_out_control), 32'd3);
            check("hold_en",   32'(enable), 32'd0);
        end
        step(0, 0, 0);
        check("d3_waddr", 32'(write_addr), 32'd3);
        check("d3_raddr", 32'(read_addr), 32'd0);
        check("d3_envr",  32'(enable_V_reg), 32'd1);
        check("d3_ensh",  32'(enable_shift), 32'd0);
        done_at = -1;
        for (int k = 9; k <= 16; k++) begin
            step(0, 0, 0);
            if (done && done_at < 0) done_at = k;
        end
        check("hold_done_cycle", 32'(done_at), 32'd13);

        // Abort at iteration 1, digit 1
        step(1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0);
        check("abort_pre_iter", 32'(iter_count), 32'd1);
        check("abort_pre_d",    32'(comp_cycle), 32'd1);
        step(0, 1, 0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_coc",  32'(carry_out_control), 32'd0);
        done_at = -1;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0);
            if (done) done_at = k;
        end
        check("abort_no_done", 32'(done_at), 32'hFFFF_FFFF);

        // Start together with abort in IDLE stays idle
        step(1, 1, 0);
        check("start_abort_idle", 32'(busy), 32'd0);

        // Async reset mid-RUN, then a full operation
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        async_reset_midcycle();
        step(1, 0, 0);
        done_at = -1;
        for (int k = 2; k <= 12; k++) begin
            step(0, 0, 0);
            if (done && done_at < 0) done_at = k;
        end
        check("post_rst_done", 32'(done_at), 32'd10);

        // Start held high: busy start pulses ignored, restart after DONE
        step(1, 0, 0);
        prev_busy = busy;
        done_at = -1;
        rise_at = -1;
        for (int k = 2; k <= 14; k++) begin
            step(1, 0, 0);
            if (done && done_at < 0) done_at = k;
            if (busy && !prev_busy && rise_at < 0) rise_at = k;
            prev_busy = busy;
        end
        check("held_done",    32'(done_at), 32'd10);
        check("held_restart", 32'(rise_at), 32'd12);
        for (int k = 0; k < 12; k++) step(0, 0, 0);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_midcycle();
            end else begin
                step($urandom_range(0, 9) < 3,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
